// File: rtl/chip_readout_sampler.sv
// ============================================================================
// Module   : chip_readout_sampler
// Brief    : Strobes a stochastic chip, samples its 4 synchronized output bits
//            and accumulates per-bit ones-counts over a requested run length.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module chip_readout_sampler #(
  parameter int CntWidth     = 8,
  parameter int SettleCycles = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic [CntWidth-1:0]   num_samples_i,
  output logic                  read_out_o,
  input  logic [3:0]            bit_i,
  output logic                  busy_o,
  output logic [4*CntWidth-1:0] count_o,
  output logic                  valid_o,
  input  logic                  ready_i
);

  localparam logic [2:0] c_IDLE   = 3'd0;
  localparam logic [2:0] c_PULSE  = 3'd1;
  localparam logic [2:0] c_SETTLE = 3'd2;
  localparam logic [2:0] c_SAMPLE = 3'd3;
  localparam logic [2:0] c_DONE   = 3'd4;

  localparam logic [3:0]          c_SETTLE_LAST = 4'(SettleCycles - 1);
  localparam logic [CntWidth-1:0] c_ONE         = {{(CntWidth-1){1'b0}}, 1'b1};

  logic [2:0]          r_state;
  logic [2:0]          w_next_state;
  logic [3:0]          r_sync1;
  logic [3:0]          r_sync2;
  logic [CntWidth-1:0] r_num;
  logic [CntWidth-1:0] r_sample_cnt;
  logic [CntWidth-1:0] w_sample_inc;
  logic [3:0]          r_settle_cnt;
  logic                r_read_out;
  logic                r_valid;
  logic                w_active;
  logic                w_accept;
  logic                w_clear;
  logic                w_sample_en;
  logic [CntWidth-1:0] r_cnt [4];

  assign w_active     = (r_state == c_PULSE) || (r_state == c_SETTLE) || (r_state == c_SAMPLE);
  assign w_accept     = (r_state == c_IDLE) && start_i;
  assign w_clear      = w_accept || (w_active && abort_i);
  assign w_sample_en  = (r_state == c_SAMPLE) && !abort_i;
  assign w_sample_inc = r_sample_cnt + c_ONE;

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_IDLE: begin
        if (start_i) begin
          w_next_state = (num_samples_i != '0) ? c_PULSE : c_DONE;
        end
      end
      c_PULSE: begin
        w_next_state = abort_i ? c_IDLE : c_SETTLE;
      end
      c_SETTLE: begin
        if (abort_i) begin
          w_next_state = c_IDLE;
        end else if (r_settle_cnt == c_SETTLE_LAST) begin
          w_next_state = c_SAMPLE;
        end
      end
      c_SAMPLE: begin
        // Abort wins over the end-of-run exit.
        if (abort_i) begin
          w_next_state = c_IDLE;
        end else begin
          w_next_state = (w_sample_inc == r_num) ? c_DONE : c_PULSE;
        end
      end
      c_DONE: begin
        if (ready_i) begin
          w_next_state = c_IDLE;
        end
      end
      default: w_next_state = c_IDLE;
    endcase
  end

  // Two-flop synchronizer for the asynchronous chip outputs.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= bit_i;
      r_sync2 <= r_sync1;
    end
  end

  // Strobe and valid are decoded from the next state so they leave flops.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state      <= c_IDLE;
      r_read_out   <= 1'b0;
      r_valid      <= 1'b0;
      r_settle_cnt <= '0;
      r_num        <= '0;
      r_sample_cnt <= '0;
    end else begin
      r_state      <= w_next_state;
      r_read_out   <= (w_next_state == c_PULSE);
      r_valid      <= (w_next_state == c_DONE);
      r_settle_cnt <= (r_state == c_SETTLE) ? r_settle_cnt + 4'd1 : 4'd0;
      if (w_accept) begin
        r_num <= num_samples_i;
      end
      if (w_clear) begin
        r_sample_cnt <= '0;
      end else if (w_sample_en) begin
        r_sample_cnt <= w_sample_inc;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_cnt
      always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
          r_cnt[gi] <= '0;
        end else if (w_clear) begin
          r_cnt[gi] <= '0;
        end else if (w_sample_en) begin
          r_cnt[gi] <= r_cnt[gi] + {{(CntWidth-1){1'b0}}, r_sync2[gi]};
        end
      end
      assign count_o[CntWidth*(gi+1)-1 -: CntWidth] = r_cnt[gi];
    end
  endgenerate

  assign read_out_o = r_read_out;
  assign valid_o    = r_valid;
  assign busy_o     = (r_state != c_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_chip_readout_sampler.sv
// ============================================================================
// Module   : tb_chip_readout_sampler
// Brief    : Directed and randomized runs of chip_readout_sampler against a
//            per-sample bit-sum model of the expected strobe timing and counts.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_chip_readout_sampler;

  localparam int CW = 8;
  localparam int SC = 3;
  localparam int P  = 2 + SC;

  logic            clk_i = 1'b0;
  logic            rst_ni = 1'b0;
  logic            start_i = 1'b0;
  logic            abort_i = 1'b0;
  logic [CW-1:0]   num_samples_i = '0;
  logic            read_out_o;
  logic [3:0]      bit_i = 4'd0;
  logic            busy_o;
  logic [4*CW-1:0] count_o;
  logic            valid_o;
  logic            ready_i = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  logic [3:0] q_bits [$];

  chip_readout_sampler #(.CntWidth(CW), .SettleCycles(SC)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .start_i       (start_i),
    .abort_i       (abort_i),
    .num_samples_i (num_samples_i),
    .read_out_o    (read_out_o),
    .bit_i         (bit_i),
    .busy_o        (busy_o),
    .count_o       (count_o),
    .valid_o       (valid_o),
    .ready_i       (ready_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_read_out"}, 32'(read_out_o), 32'd0);
    chk({tag, "_valid"},    32'(valid_o),    32'd0);
    chk({tag, "_busy"},     32'(busy_o),     32'd0);
    chk({tag, "_count"},    count_o,         32'd0);
  endtask

  // One run with the sample bits taken from q_bits; abort_t / rst_t name the
  // cycle (1-based after start) in which abort or reset is held, 0 for none.
  task automatic do_run(input string tag, input int n, input int abort_t,
                        input int rst_t, input int hold, input bit poke);
    int exp_cnt [4];
    logic [31:0] exp_vec;
    for (int i = 0; i < 4; i++) exp_cnt[i] = 0;
    start_i       = 1'b1;
    num_samples_i = CW'(n);
    if (n > 0) bit_i = q_bits[0];
    step();
    start_i       = 1'b0;
    num_samples_i = CW'($urandom);
    for (int t = 1; t <= n * P; t++) begin
      int j  = (t - 1) / P;
      int ph = (t - 1) % P;
      if (ph == 0) bit_i = q_bits[j];
      chk({tag, "_strobe"}, 32'(read_out_o), 32'(ph == 0));
      chk({tag, "_run_valid"}, 32'(valid_o), 32'd0);
      chk({tag, "_run_busy"}, 32'(busy_o), 32'd1);
      if (t == abort_t) abort_i = 1'b1;
      if (t == rst_t)   rst_ni  = 1'b0;
      step();
      abort_i = 1'b0;
      if (t == abort_t || t == rst_t) begin
        rst_ni = 1'b1;
        chk_idle_zero({tag, "_cut"});
        for (int k = 0; k < 2 * P; k++) begin
          step();
          chk({tag, "_cut_quiet_strobe"}, 32'(read_out_o), 32'd0);
          chk({tag, "_cut_quiet_valid"},  32'(valid_o),    32'd0);
        end
        return;
      end
      if (ph == P - 1) begin
        for (int i = 0; i < 4; i++) exp_cnt[i] += int'(q_bits[j][i]);
      end
    end
    exp_vec = {8'(exp_cnt[3]), 8'(exp_cnt[2]), 8'(exp_cnt[1]), 8'(exp_cnt[0])};
    chk({tag, "_valid"}, 32'(valid_o), 32'd1);
    chk({tag, "_done_strobe"}, 32'(read_out_o), 32'd0);
    chk({tag, "_count"}, count_o, exp_vec);
    for (int h = 0; h < hold; h++) begin
      if (poke) begin
        start_i       = 1'($urandom);
        abort_i       = 1'($urandom);
        num_samples_i = CW'($urandom);
      end
      step();
      chk({tag, "_hold_valid"}, 32'(valid_o), 32'd1);
      chk({tag, "_hold_count"}, count_o, exp_vec);
      chk({tag, "_hold_strobe"}, 32'(read_out_o), 32'd0);
    end
    start_i = 1'b0;
    abort_i = 1'b0;
    ready_i = 1'b1;
    step();
    ready_i = 1'b0;
    chk({tag, "_exit_valid"}, 32'(valid_o), 32'd0);
    chk({tag, "_exit_busy"}, 32'(busy_o), 32'd0);
    chk({tag, "_retain"}, count_o, exp_vec);
    abort_i = 1'b1;
    step();
    abort_i = 1'b0;
    chk({tag, "_idle_abort_busy"}, 32'(busy_o), 32'd0);
    chk({tag, "_idle_abort_count"}, count_o, exp_vec);
  endtask

  initial begin
    int n;
    // Reset state and quiet release.
    rst_ni = 1'b0;
    step();
    chk_idle_zero("reset");
    rst_ni = 1'b1;
    step();
    chk_idle_zero("release");

    // Single sample, constant 1010.
    q_bits = '{4'b1010};
    do_run("n1", 1, 0, 0, 2, 1'b0);

    // Zero-length run goes straight to DONE.
    q_bits = '{};
    do_run("n0", 0, 0, 0, 1, 1'b0);

    // bit0 high on samples 1 and 3 only.
    q_bits = '{};
    for (int j = 0; j < 4; j++) q_bits.push_back({3'($urandom), 1'(j % 2 == 0)});
    do_run("n4", 4, 0, 0, 0, 1'b0);

    // DONE held with start/abort pokes for 10 cycles.
    q_bits = '{};
    for (int j = 0; j < 3; j++) q_bits.push_back(4'($urandom));
    do_run("hold", 3, 0, 0, 10, 1'b1);

    // Randomized runs.
    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(1, 20);
      q_bits = '{};
      for (int j = 0; j < n; j++) q_bits.push_back(4'($urandom));
      do_run("rand", n, 0, 0, $urandom_range(0, 3), 1'b1);
    end

    // Abort in second SETTLE of an N=5 run, then immediate restart.
    q_bits = '{};
    for (int j = 0; j < 5; j++) q_bits.push_back(4'b1111);
    do_run("abort_settle", 5, P + 3, 0, 0, 1'b0);
    q_bits = '{4'b0110, 4'b0011};
    do_run("after_abort", 2, 0, 0, 1, 1'b0);

    // Abort in the final SAMPLE beats the exit to DONE.
    q_bits = '{4'b1111};
    do_run("abort_sample", 1, P, 0, 0, 1'b0);

    // Reset mid-run.
    q_bits = '{};
    for (int j = 0; j < 6; j++) q_bits.push_back(4'b1111);
    do_run("midreset", 6, 0, P + 2, 0, 1'b0);

    // Full-scale run, no wrap.
    q_bits = '{};
    for (int j = 0; j < 255; j++) q_bits.push_back(4'b1111);
    do_run("n255", 255, 0, 0, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/chip_readout_sampler.md
CHIP_READOUT_SAMPLER -- requirements
Module: chip_readout_sampler

Interface
REQ-001 Parameter CntWidth, default 8: width of each per-bit counter and of num_samples_i.
REQ-002 Parameter SettleCycles, default 3, legal range 2..15: cycles between the read_out_o pulse and the sample, covering chip settling plus the 2-flop synchronizer.
REQ-003 clk_i  input  1  single system clock (divided chip-side clock domain).
REQ-004 rst_ni  input  1  reset, synchronous, active-low.
REQ-005 start_i  input  1  request for one sampling run; honoured only in IDLE.
REQ-006 abort_i  input  1  cancel the current run.
REQ-007 num_samples_i  input  CntWidth  number of read strobes in the run; captured on start acceptance.
REQ-008 read_out_o  output  1  read strobe to the chip.
REQ-009 bit_i  input  4  stochastic output bits from the chip (DATA_out), asynchronous to clk_i.
REQ-010 busy_o  output  1  high in every state except IDLE.
REQ-011 count_o  output  4*CntWidth  ones-counts; bits [CntWidth*(i+1)-1 : CntWidth*i] belong to bit_i[i].
REQ-012 valid_o  output  1  result available.
REQ-013 ready_i  input  1  consumer accepts result.

Function
REQ-014 bit_i SHALL pass through a 2-flop synchronizer clocked every cycle; only the synchronized value is ever sampled.
REQ-015 The FSM SHALL have the states IDLE, PULSE, SETTLE, SAMPLE and DONE.
REQ-016 IDLE: when start_i=1 and num_samples_i!=0, it captures num_samples_i, clears all four counters and the sample counter, and goes to PULSE.
REQ-017 IDLE: when start_i=1 and num_samples_i==0, it clears the counters and goes directly to DONE; no read_out_o pulse is issued.
REQ-018 PULSE: lasts exactly 1 cycle with read_out_o=1, then goes to SETTLE; read_out_o SHALL be 0 in every other state.
REQ-019 SETTLE: lasts exactly SettleCycles cycles, then goes to SAMPLE.
REQ-020 SAMPLE: lasts 1 cycle; each counter i increments by the synchronized bit i and the sample counter increments.
REQ-021 SAMPLE exit: if the sample counter reaches the captured count, go to DONE; otherwise go to PULSE.
REQ-022 Each sample therefore takes 2+SettleCycles cycles.
REQ-023 Latency: with start accepted at clock edge k, valid_o SHALL first be high in cycle k + N*(2+SettleCycles) + 1.
REQ-024 Counters SHALL NOT wrap; the maximum value N = 2^CntWidth-1 is representable by construction.
REQ-025 DONE: valid_o=1 and count_o is held stable.
REQ-026 DONE exit: on the first cycle with ready_i=1, valid_o drops on the next cycle and the FSM returns to IDLE.
REQ-027 count_o SHALL retain its value in IDLE until the next start is accepted.
REQ-028 start_i SHALL be ignored in every state except IDLE, including in DONE.
REQ-029 abort_i=1 in PULSE, SETTLE or SAMPLE SHALL return the FSM to IDLE on the next cycle, force read_out_o=0, clear the counters and leave valid_o low.
REQ-030 abort_i SHALL have no effect in IDLE or DONE.
REQ-031 abort_i SHALL have priority over the sample-counter exit in SAMPLE.
REQ-032 valid_o and read_out_o SHALL be driven directly from registers, with no combinational path from any input.

Reset
REQ-033 When rst_ni=0 at a rising edge of clk_i: state=IDLE, read_out_o=0, busy_o=0, valid_o=0, count_o=0, sample counter=0, synchronizer flops=0.
REQ-034 Reset asserted mid-run SHALL take effect at the next edge, with no further read_out_o pulse and no valid_o.
REQ-035 No output SHALL change on a reset deassertion edge except through normal FSM operation.

Verification
REQ-036 N=1, SettleCycles=3, bit_i=4'b1010 constant, start at edge 0 -> read_out_o high in cycle 1 only, valid_o high from cycle 6, count_o = {1,0,1,0} (bit3..bit0).
REQ-037 N=255, bit_i=4'b1111 constant, ready_i=1 -> 255 read_out_o pulses, count_o all 255 with no wrap, valid_o high for exactly 1 cycle.
REQ-038 N=4, bit_i[0] toggled so the synchronized value is 1 on samples 1 and 3 only -> count for bit 0 = 2.
REQ-039 N=0 start -> zero read_out_o pulses, valid_o high on the cycle after start, count_o=0.
REQ-040 abort_i during the second SETTLE of an N=5 run -> IDLE next cycle, valid_o never high, count_o=0; a new start is accepted immediately afterwards.
REQ-041 In DONE, hold ready_i=0 for 10 cycles while pulsing start_i and abort_i -> valid_o and count_o unchanged; ready_i=1 -> IDLE.
REQ-042 rst_ni=0 for 1 cycle mid-run -> all outputs 0 at the next edge, no further read_out_o pulse.
